// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the serial transmitter.
// Build option: define UART_TX_TWO_STOP_EN to send two stop bits per frame
// (STOP_COUNT=2); leave it undefined for a single stop bit.
package uart_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // parityType encodings
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Clock cycles per serial bit, matched to the receiver's 16x sampling
  localparam int DEFAULT_OVERSAMPLE = 16;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_COUNT = 2;
`else
  localparam int STOP_COUNT = 1;
`endif

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: OVERSAMPLE-modulo bit timer. Counts 0..OVERSAMPLE-1
// while enabled and strobes tick on the terminal count, then restarts at 0.
// clear forces the count back to 0 so a new frame starts on a bit boundary.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;

  // Terminal-count strobe: only meaningful while the timer is running
  always_comb begin
    tick_s = 1'b0;
    if (enable && (cnt_r == CNT_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  assign tick = tick_s;

  // Cycle counter within the current serial bit; never runs past CNT_LAST
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (tick_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_serial_transmitter.sv
// uart_serial_transmitter: serialises a latched byte as
// start(0), DATA_BITS LSB-first, optional parity, stop(1), each bit held
// OVERSAMPLE cycles. All outputs come straight from flops.
// Build option: UART_TX_TWO_STOP_EN selects two stop bits (see uart_pkg).
module uart_serial_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 parity,
  input  logic                 parityType,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic             STOP_LAST = 1'(STOP_COUNT - 1);

  tx_state_t            state_r;
  logic [DATA_BITS-1:0] data_lat_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic                 stop_cnt_r;
  logic                 par_en_r;
  logic                 par_type_r;
  logic                 out_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 accept_s;
  logic                 timer_en_s;
  logic                 tick_s;

  // Parity bit so the total count of ones (payload plus this bit) is even or odd
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d,
                                       input logic                 ptype);
    logic ones_odd;
    ones_odd = ^d;
    case (ptype)
      PARITY_EVEN: calc_parity = ones_odd;
      PARITY_ODD:  calc_parity = ~ones_odd;
      default:     calc_parity = ones_odd;
    endcase
  endfunction

  // Accept a request only in IDLE; the bit timer runs for the whole frame
  always_comb begin
    accept_s   = 1'b0;
    timer_en_s = 1'b0;
    if (state_r == IDLE) begin
      accept_s   = start;
      timer_en_s = 1'b0;
    end else begin
      accept_s   = 1'b0;
      timer_en_s = 1'b1;
    end
  end

  uart_tx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept_s),
    .enable (timer_en_s),
    .tick   (tick_s)
  );

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      data_lat_r <= '0;
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      stop_cnt_r <= 1'b0;
      par_en_r   <= 1'b0;
      par_type_r <= 1'b0;
      out_r      <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            data_lat_r <= data;
            shift_r    <= data;
            par_en_r   <= parity;
            par_type_r <= parityType;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
            state_r    <= START;
            out_r      <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            out_r  <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            state_r   <= DATA;
            out_r     <= shift_r[0];
            bit_cnt_r <= '0;
          end
        end
        DATA: begin
          if (tick_s) begin
            shift_r <= shift_r >> 1;
            if (bit_cnt_r == BIT_LAST) begin
              if (par_en_r) begin
                state_r <= PARITY;
                out_r   <= calc_parity(data_lat_r, par_type_r);
              end else begin
                state_r    <= STOP;
                out_r      <= 1'b1;
                stop_cnt_r <= 1'b0;
              end
            end else begin
              out_r     <= shift_r[1];
              bit_cnt_r <= bit_cnt_r + BIT_ONE;
            end
          end
        end
        PARITY: begin
          if (tick_s) begin
            state_r    <= STOP;
            out_r      <= 1'b1;
            stop_cnt_r <= 1'b0;
          end
        end
        STOP: begin
          if (tick_s) begin
            if (stop_cnt_r == STOP_LAST) begin
              state_r    <= IDLE;
              out_r      <= 1'b1;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              stop_cnt_r <= 1'b0;
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          out_r   <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = out_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_serial_transmitter.sv
// tb_uart_serial_transmitter: directed, table-driven bench for the transmitter
// (OVERSAMPLE=16, DATA_BITS=8), plus hand-written mid-frame reset and
// back-to-back loop-back sequences. Honours UART_TX_TWO_STOP_EN.
module tb_uart_serial_transmitter;

`ifdef UART_TX_TWO_STOP_EN
  localparam int N_STOP = 2;
`else
  localparam int N_STOP = 1;
`endif
  localparam int OS = 16;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic       parity;
  logic       parityType;
  logic       out;
  logic       busy;
  logic       done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // One frame: bits[] lists start, data LSB-first, optional parity, first stop
  typedef struct {
    logic [7:0]  dat;
    logic        par;
    logic        ptype;
    int          nb;
    logic [0:10] bits;
  } vec_t;

  vec_t vecs[8];

  uart_serial_transmitter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data       (data),
    .parity     (parity),
    .parityType (parityType),
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Send one vector and check every cycle of the frame; a competing request
  // with different inputs is pulsed at cycle 40 and must have no effect.
  task automatic send_frame(input vec_t v, input int idx);
    int   good[16];
    int   busy_ok;
    int   nbits;
    int   b;
    logic expb;
    nbits   = v.nb + N_STOP - 1;
    busy_ok = 0;
    for (int i = 0; i < 16; i++) good[i] = 0;
    @(negedge clk);
    start      = 1'b1;
    data       = v.dat;
    parity     = v.par;
    parityType = v.ptype;
    @(posedge clk);
    #1;
    start = 1'b0;
    check($sformatf("v%0d_accept", idx), {out, busy, done}, 3'b010);
    for (int k = 0; k < nbits * OS; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      b    = k / OS;
      expb = (b < v.nb) ? v.bits[b] : 1'b1;
      if (out === expb) good[b]++;
      if (busy === 1'b1 && done === 1'b0) busy_ok++;
      if (k == 40) begin
        start      = 1'b1;
        data       = (v.dat == 8'h3C) ? 8'hFF : ~v.dat;
        parity     = ~v.par;
        parityType = ~v.ptype;
      end else if (k == 41) begin
        start = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check($sformatf("v%0d_done_edge", idx), {out, busy, done}, 3'b101);
    for (int i = 0; i < nbits; i++) begin
      check($sformatf("v%0d_bit%0d_cycles_ok", idx, i), good[i], OS);
    end
    check($sformatf("v%0d_busy_cycles", idx), busy_ok, nbits * OS);
    @(posedge clk);
    #1;
    check($sformatf("v%0d_done_one_cycle", idx), {out, busy, done}, 3'b100);
  endtask

  initial begin
    int         ok;
    int         found;
    int         st;
    int         dn;
    int         prev_dn;
    logic [7:0] rx;
    logic [7:0] txb[3];

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 11'b0_1010_0101_1_1};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 11, 11'b0_1010_0101_0_1};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 11, 11'b0_1010_0101_1_1};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 10, 11'b0_0011_1100_1_1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 11, 11'b0_0000_0000_1_1};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 11, 11'b0_1111_1111_0_1};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 11, 11'b0_1000_0000_1_1};
    vecs[7] = '{8'hC3, 1'b1, 1'b1, 11, 11'b0_1100_0011_1_1};

    reset      = 1'b1;
    start      = 1'b0;
    data       = 8'h00;
    parity     = 1'b0;
    parityType = 1'b0;

    // Reset for 3 cycles, then 20 idle cycles: line high, not busy, no done
    ok = 0;
    for (int i = 0; i < 23; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) check("reset_state", {out, busy, done}, 3'b100);
      if (i == 2) reset = 1'b0;
      if (out === 1'b1 && busy === 1'b0 && done === 1'b0) ok++;
    end
    check("reset_then_idle_cycles", ok, 23);

    for (int i = 0; i < 8; i++) send_frame(vecs[i], i);

    // Reset at cycle 70 of a frame abandons it; a fresh frame is clean
    @(negedge clk);
    start  = 1'b1;
    data   = 8'hA5;
    parity = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midframe_reset", {out, busy, done}, 3'b100);
    ok = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out === 1'b1 && busy === 1'b0 && done === 1'b0) ok++;
    end
    check("after_reset_idle", ok, 5);
    send_frame(vecs[0], 8);

    // start held high: three back-to-back frames decoded by a receiver model
    txb[0]     = 8'h5A;
    txb[1]     = 8'hC3;
    txb[2]     = 8'h81;
    parity     = 1'b0;
    parityType = 1'b0;
    prev_dn    = 0;
    @(negedge clk);
    data  = txb[0];
    start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      found = 0;
      for (int w = 0; w < 64 && found == 0; w++) begin
        @(posedge clk);
        #1;
        if (out === 1'b0) found = 1;
      end
      check($sformatf("rx%0d_start_seen", f), found, 1);
      st   = cyc;
      data = txb[(f + 1) % 3];
      if (f > 0) check($sformatf("rx%0d_idle_gap", f), st - prev_dn, 1);
      repeat (OS / 2) @(posedge clk);
      #1;
      check($sformatf("rx%0d_start_qualify", f), out, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (OS) @(posedge clk);
        #1;
        rx[i] = out;
      end
      for (int s = 0; s < N_STOP; s++) begin
        repeat (OS) @(posedge clk);
        #1;
        check($sformatf("rx%0d_stop%0d", f, s), out, 1'b1);
      end
      check($sformatf("rx%0d_byte", f), rx, txb[f]);
      found = 0;
      for (int w = 0; w < 40 && found == 0; w++) begin
        @(posedge clk);
        #1;
        if (done === 1'b1) found = 1;
      end
      check($sformatf("rx%0d_done_seen", f), found, 1);
      dn = cyc;
      check($sformatf("rx%0d_frame_len", f), dn - st, OS * (9 + N_STOP));
      prev_dn = dn;
      if (f == 2) start = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out === 1'b1 && busy === 1'b0 && done === 1'b0) ok++;
    end
    check("idle_after_burst", ok, 10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
